// File: rtl/mips_multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl_if
// Bundle between the instruction register / datapath and the multicycle
// control unit: instruction fields and ALU Zero flow into the controller,
// mux selects, write enables, ALU function code and debug state flow out.
// master = datapath side, slave = control unit side.
// ---------------------------------------------------------------------------
interface mips_multicycle_ctrl_if;
    // Datapath -> controller
    logic [5:0] op;          // instr[31:26]
    logic [5:0] funct;       // instr[5:0]
    logic       zero;        // ALU Zero flag, same cycle

    // Controller -> datapath
    logic       iord;        // memory address: 0 = PC, 1 = ALUOut
    logic       memwrite;    // data memory write enable
    logic       irwrite;     // instruction register load enable
    logic       regdst;      // write address: 0 = rt, 1 = rd
    logic       memtoreg;    // write data: 0 = ALUOut, 1 = Data register
    logic       regwrite;    // register file we3
    logic       alusrca;     // ALU A: 0 = PC, 1 = register A
    logic [1:0] alusrcb;     // ALU B: B, 4, SignImm, SignImm<<2
    logic [1:0] pcsrc;       // PC next: ALUResult, ALUOut, jump target
    logic       pcen;        // PC flop enable
    logic [3:0] alucontrol;  // ALU F, bit 3 always 0
    logic [3:0] state;       // current FSM state, debug only

    modport master (
        output op, funct, zero,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, state
    );

    modport slave (
        input  op, funct, zero,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
// Moore control FSM for the multicycle MIPS datapath. Sequences the shared
// ALU, register file, unified memory port and PC over 3-5 cycles per
// instruction (lw 5, sw/R-type/addi 4, beq/j 3, unknown op 2).
//
// Optional feature: define MIPS_CTRL_BNE_EN to decode bne (op 000101) into
// the BRANCH state; op[0] then picks between branch-on-zero (beq) and
// branch-on-not-zero (bne). Without the macro bne is treated as an unknown
// op and BRANCH always branches on zero.
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl (
    input  logic                   clk,
    input  logic                   reset,
    mips_multicycle_ctrl_if.slave  bus
);

    // State encodings are visible on the debug port, so they are pinned.
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    // Opcodes recognised in DECODE
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    // ALU operation classes handed to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU function codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    state_t     state_q;
    state_t     state_d;
    logic       pcwrite;
    logic       branch;
    logic       outputs_off;   // unused state encodings: everything driven to 0
    logic [1:0] aluop;
    logic [3:0] alu_decoded;
    logic       branch_cond;

    // State register; reset forces FETCH so outputs take FETCH values while held.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge value of state_d, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DECODE dispatches on op, MEMADR splits lw/sw.
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW,
                    OP_SW:    state_d = MEMADR;
                    OP_RTYPE: state_d = EXECUTE;
                    OP_BEQ:   state_d = BRANCH;
`ifdef MIPS_CTRL_BNE_EN
                    OP_BNE:   state_d = BRANCH;
`endif
                    OP_ADDI:  state_d = ADDIEX;
                    OP_J:     state_d = JUMP;
                    default:  state_d = FETCH;   // unknown op runs as a NOP
                endcase
            end
            MEMADR:  state_d = (bus.op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_d = MEMWB;
            MEMWB:   state_d = FETCH;
            MEMWR:   state_d = FETCH;
            EXECUTE: state_d = ALUWB;
            ALUWB:   state_d = FETCH;
            BRANCH:  state_d = FETCH;
            ADDIEX:  state_d = ADDIWB;
            ADDIWB:  state_d = FETCH;
            JUMP:    state_d = FETCH;
            default: state_d = FETCH;   // encodings 12-15 recover in one edge
        endcase
    end

    // Moore outputs per state; anything not listed for a state stays 0.
    always_comb begin
        bus.iord     = 1'b0;
        bus.memwrite = 1'b0;
        bus.irwrite  = 1'b0;
        bus.regdst   = 1'b0;
        bus.memtoreg = 1'b0;
        bus.regwrite = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = 2'b00;
        bus.pcsrc    = 2'b00;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        aluop        = ALUOP_ADD;
        outputs_off  = 1'b0;
        case (state_q)
            FETCH: begin
                bus.irwrite = 1'b1;
                pcwrite     = 1'b1;
                bus.alusrcb = 2'b01;            // PC + 4
            end
            DECODE: begin
                bus.alusrcb = 2'b11;            // speculative branch target
            end
            MEMADR,
            ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;            // A + SignImm
            end
            MEMRD: begin
                bus.iord = 1'b1;
            end
            MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
            end
            MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
            end
            EXECUTE: begin
                bus.alusrca = 1'b1;
                aluop       = ALUOP_FUNCT;
            end
            ALUWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
            end
            BRANCH: begin
                bus.alusrca = 1'b1;
                bus.pcsrc   = 2'b01;            // target computed in DECODE
                branch      = 1'b1;
                aluop       = ALUOP_SUB;
            end
            ADDIWB: begin
                bus.regwrite = 1'b1;
            end
            JUMP: begin
                bus.pcsrc = 2'b10;
                pcwrite   = 1'b1;
            end
            default: begin
                outputs_off = 1'b1;
            end
        endcase
    end

    // ALU decoder: fixed add/sub for address and branch work, funct for R-type.
    always_comb begin
        alu_decoded = ALU_AND;
        case (aluop)
            ALUOP_ADD: alu_decoded = ALU_ADD;
            ALUOP_SUB: alu_decoded = ALU_SUB;
            ALUOP_FUNCT: begin
                case (bus.funct)
                    6'b100000: alu_decoded = ALU_ADD;
                    6'b100010: alu_decoded = ALU_SUB;
                    6'b100100: alu_decoded = ALU_AND;
                    6'b100101: alu_decoded = ALU_OR;
                    6'b101010: alu_decoded = ALU_SLT;
                    default:   alu_decoded = ALU_AND;
                endcase
            end
            default: alu_decoded = ALU_AND;
        endcase
    end

    // Branch condition: op[0] selects bne polarity only when bne is built in.
`ifdef MIPS_CTRL_BNE_EN
    assign branch_cond = bus.op[0] ? ~bus.zero : bus.zero;
`else
    assign branch_cond = bus.zero;
`endif

    assign bus.pcen       = pcwrite | (branch & branch_cond);
    assign bus.alucontrol = outputs_off ? 4'b0000 : alu_decoded;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
// Directed bench for the multicycle MIPS control FSM. Each instruction pushes
// its expected per-cycle state and control vector onto a scoreboard queue;
// entries are popped and compared one per cycle on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcen;
        logic [3:0] alucontrol;
    } ctrl_t;

    typedef struct {
        string      tag;
        logic [3:0] st;
        ctrl_t      c;
    } exp_t;

    // Expected control vectors, written straight from the state table
    localparam ctrl_t C_FETCH  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 4'b0010};
    localparam ctrl_t C_DECODE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 4'b0010};
    localparam ctrl_t C_MEMADR = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 4'b0010};
    localparam ctrl_t C_MEMRD  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'b0010};
    localparam ctrl_t C_MEMWB  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 4'b0010};
    localparam ctrl_t C_MEMWR  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'b0010};
    localparam ctrl_t C_ALUWB  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 4'b0010};
    localparam ctrl_t C_ADDIEX = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 4'b0010};
    localparam ctrl_t C_ADDIWB = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 4'b0010};
    localparam ctrl_t C_JUMP   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 4'b0010};

    function automatic ctrl_t c_execute(input logic [3:0] alu);
        return '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, alu};
    endfunction

    function automatic ctrl_t c_branch(input logic taken);
        return '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, taken, 4'b0110};
    endfunction

    logic  clk;
    logic  reset;
    ctrl_t obs;
    exp_t  sb[$];
    int    n_pass;
    int    n_total;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    assign obs = {bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
                  bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.pcen,
                  bus.alucontrol};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [3:0] st, input ctrl_t c);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.c   = c;
        sb.push_back(e);
    endtask

    // Pop one expectation and compare it against the settled DUT outputs.
    task automatic check_now();
        exp_t e;
        #1;
        if (sb.size() == 0) begin
            n_total++;
            $error("FAIL scoreboard_empty: got no expectation, required one");
            return;
        end
        e = sb.pop_front();
        n_total++;
        assert (bus.state === e.st) n_pass++;
        else $error("FAIL %s state: got %0d required %0d", e.tag, bus.state, e.st);
        n_total++;
        assert (obs === e.c) n_pass++;
        else $error("FAIL %s ctrl: got %h required %h", e.tag, obs, e.c);
    endtask

    // Compare the first queued entry now, then one entry per falling edge.
    task automatic drain();
        check_now();
        while (sb.size() != 0) begin
            @(negedge clk);
            check_now();
        end
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] funct, input logic zero);
        bus.op    = op;
        bus.funct = funct;
        bus.zero  = zero;
    endtask

    logic [5:0] funct_tab [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    logic [3:0] alu_tab   [6] = '{4'b0010,   4'b0110,   4'b0000,   4'b0001,   4'b0111,   4'b0000};

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        set_instr(6'b000000, 6'b000000, 1'b0);

        // Reset held three cycles: FETCH values throughout
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            push("reset_hold", 4'd0, C_FETCH);
            check_now();
        end

        // lw: 0,1,2,3,4
        reset = 1'b0;
        set_instr(6'b100011, 6'b000000, 1'b0);
        push("lw_fetch", 4'd0, C_FETCH);
        push("lw_decode", 4'd1, C_DECODE);
        push("lw_memadr", 4'd2, C_MEMADR);
        push("lw_memrd", 4'd3, C_MEMRD);
        push("lw_memwb", 4'd4, C_MEMWB);
        drain();

        // sw: 0,1,2,5
        @(negedge clk);
        set_instr(6'b101011, 6'b000000, 1'b1);
        push("sw_fetch", 4'd0, C_FETCH);
        push("sw_decode", 4'd1, C_DECODE);
        push("sw_memadr", 4'd2, C_MEMADR);
        push("sw_memwr", 4'd5, C_MEMWR);
        drain();

        // R-type across the funct table, including an unknown funct
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_instr(6'b000000, funct_tab[i], 1'b0);
            push("r_fetch", 4'd0, C_FETCH);
            push("r_decode", 4'd1, C_DECODE);
            push($sformatf("r_execute_f%b", funct_tab[i]), 4'd6, c_execute(alu_tab[i]));
            push("r_aluwb", 4'd7, C_ALUWB);
            drain();
        end

        // beq taken and not taken
        for (int z = 1; z >= 0; z--) begin
            @(negedge clk);
            set_instr(6'b000100, 6'b000000, z[0]);
            push("beq_fetch", 4'd0, C_FETCH);
            push("beq_decode", 4'd1, C_DECODE);
            push($sformatf("beq_branch_z%0d", z), 4'd8, c_branch(z[0]));
            drain();
        end

        // addi: 0,1,9,10
        @(negedge clk);
        set_instr(6'b001000, 6'b000000, 1'b0);
        push("addi_fetch", 4'd0, C_FETCH);
        push("addi_decode", 4'd1, C_DECODE);
        push("addi_ex", 4'd9, C_ADDIEX);
        push("addi_wb", 4'd10, C_ADDIWB);
        drain();

        // j: 0,1,11
        @(negedge clk);
        set_instr(6'b000010, 6'b000000, 1'b0);
        push("j_fetch", 4'd0, C_FETCH);
        push("j_decode", 4'd1, C_DECODE);
        push("j_jump", 4'd11, C_JUMP);
        drain();

        // Unknown op: 0,1 then back to FETCH
        @(negedge clk);
        set_instr(6'b111111, 6'b000000, 1'b1);
        push("nop_fetch", 4'd0, C_FETCH);
        push("nop_decode", 4'd1, C_DECODE);
        drain();

        // bne: branch on ~zero when built in, otherwise an unknown op
        for (int z = 1; z >= 0; z--) begin
            @(negedge clk);
            set_instr(6'b000101, 6'b000000, z[0]);
            push("bne_fetch", 4'd0, C_FETCH);
            push("bne_decode", 4'd1, C_DECODE);
`ifdef MIPS_CTRL_BNE_EN
            push($sformatf("bne_branch_z%0d", z), 4'd8, c_branch(~z[0]));
`endif
            drain();
        end

        // Asynchronous reset mid-cycle while in MEMRD
        @(negedge clk);
        set_instr(6'b100011, 6'b000000, 1'b0);
        push("arst_fetch", 4'd0, C_FETCH);
        push("arst_decode", 4'd1, C_DECODE);
        push("arst_memadr", 4'd2, C_MEMADR);
        push("arst_memrd", 4'd3, C_MEMRD);
        drain();
        #2;
        reset = 1'b1;
        push("arst_immediate", 4'd0, C_FETCH);
        check_now();
        @(negedge clk);
        push("arst_held", 4'd0, C_FETCH);
        check_now();
        reset = 1'b0;
        @(negedge clk);
        push("arst_release_decode", 4'd1, C_DECODE);
        check_now();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Control unit for the multicycle MIPS datapath: one Moore FSM that sequences the shared ALU, register file, instruction/data memory port and PC across 3-5 cycles per instruction.
- Drives all mux selects, write enables and the 4-bit ALU function code.
- Sits between the instruction register (op/funct fields) and the datapath in the top-level mips module.

Parameters:
- None. State and ALU encodings are fixed below.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces state to FETCH
- op  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0] from instruction register
- zero  in  1  ALU Zero flag, same cycle
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  data memory write enable
- irwrite  out  1  instruction register load enable
- regdst  out  1  register write address: 0 = rt, 1 = rd
- memtoreg  out  1  register write data: 0 = ALUOut, 1 = Data register
- regwrite  out  1  register file write enable (we3)
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- pcsrc  out  2  PC next select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- pcen  out  1  PC flop enable
- alucontrol  out  4  ALU F; bit 3 always 0
- state  out  4  current state, for debug and bench

Behaviour:
- State register is a 4-bit flop with async reset. Reset value is FETCH (0).
- While reset is high, all outputs take their FETCH values.
- Reset asserted mid-instruction abandons the instruction. The first rising edge after release leaves FETCH normally.
- All outputs are Moore functions of state, except:
  - pcen = pcwrite | (branch & zero)
  - alucontrol also depends on funct
- States, with outputs asserted in each (unlisted outputs are 0) and transitions:
  - FETCH(0): irwrite=1, pcwrite=1, alusrcb=01, aluop=00. Next: DECODE.
  - DECODE(1): alusrcb=11, aluop=00. Next by op:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXECUTE
    - 000100 (beq) -> BRANCH
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JUMP
    - any other op -> FETCH (executes as a NOP, no writes)
  - MEMADR(2): alusrca=1, alusrcb=10, aluop=00. Next: MEMRD if lw, MEMWR if sw.
  - MEMRD(3): iord=1. Next: MEMWB.
  - MEMWB(4): memtoreg=1, regwrite=1. Next: FETCH.
  - MEMWR(5): iord=1, memwrite=1. Next: FETCH.
  - EXECUTE(6): alusrca=1, aluop=10. Next: ALUWB.
  - ALUWB(7): regdst=1, regwrite=1. Next: FETCH.
  - BRANCH(8): alusrca=1, aluop=01, pcsrc=01, branch=1. Next: FETCH.
  - ADDIEX(9): alusrca=1, alusrcb=10, aluop=00. Next: ADDIWB.
  - ADDIWB(10): regwrite=1. Next: FETCH.
  - JUMP(11): pcsrc=10, pcwrite=1. Next: FETCH.
  - Unused encodings 12-15 -> FETCH on the next edge; all outputs 0 while in them.
- ALU decode:
  - aluop 00 -> 0010 (add)
  - aluop 01 -> 0110 (sub)
  - aluop 10, by funct:
    - 100000 (add) -> 0010
    - 100010 (sub) -> 0110
    - 100100 (and) -> 0000
    - 100101 (or) -> 0001
    - 101010 (slt) -> 0111
    - any other funct -> 0000; regwrite is still issued in ALUWB
- Latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown op 2.
- memwrite and regwrite are never asserted in the same cycle.
- irwrite is asserted only in FETCH.

Optional Feature:
- Macro: MIPS_CTRL_BNE_EN.
- Defined: op 000101 (bne) decodes in DECODE to BRANCH. In BRANCH, pcen = branch & ~zero for bne and branch & zero for beq. Which of the two applies is selected by op[0], sampled in BRANCH.
- Undefined: 000101 is an unknown op (DECODE -> FETCH, no PC update beyond the FETCH increment). BRANCH ignores op[0].

Test Plan:
- Reset held 3 cycles, then released with op=100011 (lw) -> state sequence 0,1,2,3,4,0. memtoreg=1 and regwrite=1 only in state 4. iord=1 only in state 3.
- op=101011 (sw) -> states 0,1,2,5,0. memwrite=1 only in state 5. regwrite never asserted.
- op=000000, funct=101010 (slt) -> alucontrol=0111 in state 6. regdst=1 and regwrite=1 in state 7. funct=100101 (or) -> alucontrol=0001 in state 6.
- op=000100 (beq) in state 8: zero=1 -> pcen=1, pcsrc=01, alucontrol=0110; zero=0 -> pcen=0. With MIPS_CTRL_BNE_EN and op=000101: pcen follows ~zero.
- op=000010 (j) -> states 0,1,11,0 with pcsrc=10, pcen=1 in state 11. op=111111 -> states 0,1,0 with no write enable after FETCH.
- Reset pulsed asynchronously (mid-cycle) while in state 3 -> state=0 immediately, irwrite=1 and pcen=1 while reset is held. Normal FETCH->DECODE follows release.
